// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller.
// Captures a taken branch/jump target from EX, presents it to fetch until
// accepted, then holds the pipeline flushes for a fixed number of cycles so
// that wrong-path instructions drain. Also keeps saturating statistics on
// branches seen and redirects taken.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no redirect pending; EX may capture a taken target
// REDIRECT | redirect_valid high, target held until fetch_ready
// FLUSH    | redirect accepted; flushes held while the down-counter drains
module branch_redirect_ctrl #(
  parameter int PC_W         = 9,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // The counter holds the remaining FLUSH cycles after the current one,
  // so FLUSH_CYCLES=1 loads 0 and leaves FLUSH after a single cycle.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state;
  logic [3:0]      flush_cnt;
  logic [PC_W-1:0] target;
  logic            capture;
  logic            branch_seen;

  // Bits above the fetch PC width and bit 0 are architecturally dropped.
  logic unused_brpc;
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[0]};

  assign capture     = (state == IDLE) && ex_valid && PcSel;
  assign branch_seen = (state == IDLE) && ex_valid && ex_branch;
  assign redirect_pc = target;

  // Redirect sequencing FSM with all control outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      target         <= '0;
      redirect_valid <= 1'b0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      busy           <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state          <= REDIRECT;
            target         <= {BrPC[PC_W-1:1], 1'b0};
            misalign_err   <= BrPC[1];
            redirect_valid <= 1'b1;
            flush_ifid     <= 1'b1;
            flush_idex     <= 1'b1;
            busy           <= 1'b1;
          end
        end
        REDIRECT: begin
          if (fetch_ready) begin
            state          <= FLUSH;
            flush_cnt      <= FLUSH_LOAD;
            redirect_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state      <= IDLE;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
            busy       <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state          <= IDLE;
          flush_cnt      <= '0;
          redirect_valid <= 1'b0;
          flush_ifid     <= 1'b0;
          flush_idex     <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; only instructions observed while IDLE are real-path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (branch_seen && (branch_cnt != {CNT_W{1'b1}}))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (capture && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (PC_W=9,
// FLUSH_CYCLES=2, CNT_W=4 so saturation is reachable quickly).
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             ex_valid;
  logic             ex_branch;
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             busy;
  logic             misalign_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int n_checks;
  int n_fail;
  int fl_cnt;
  int fx_cnt;
  int rv_cnt;
  int mis_cnt;

  branch_redirect_ctrl #(
    .PC_W         (PC_W),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .PcSel          (PcSel),
    .BrPC           (BrPC),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .busy           (busy),
    .misalign_err   (misalign_err),
    .branch_cnt     (branch_cnt),
    .taken_cnt      (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample outputs 1ns later and tally activity.
  task automatic tick();
    @(posedge clk);
    #1;
    if (flush_ifid)     fl_cnt++;
    if (flush_idex)     fx_cnt++;
    if (redirect_valid) rv_cnt++;
    if (misalign_err)   mis_cnt++;
  endtask

  task automatic clr_tally();
    fl_cnt  = 0;
    fx_cnt  = 0;
    rv_cnt  = 0;
    mis_cnt = 0;
  endtask

  task automatic drop_inputs();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    PcSel     = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && busy; i++) tick();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_tally();
    reset       = 1'b0;
    drop_inputs();
    BrPC        = 32'd0;
    fetch_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_rv",    {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc",    32'(redirect_pc), 32'd0);
    chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
    chk("rst_cnts",  {24'd0, branch_cnt, taken_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Immediate accept: 1 redirect cycle + 2 flush cycles
    clr_tally();
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1;
    BrPC = 32'h0000_0124; fetch_ready = 1'b1;
    tick();
    chk("a_rv",   {31'd0, redirect_valid}, 32'd1);
    chk("a_pc",   32'(redirect_pc), 32'h124);
    chk("a_busy", {31'd0, busy}, 32'd1);
    drop_inputs();
    tick();
    chk("a_rv_after_accept", {31'd0, redirect_valid}, 32'd0);
    chk("a_flush_in_flush",  {31'd0, flush_ifid}, 32'd1);
    drain("a_idle");
    chk("a_fl_cnt",  32'(fl_cnt), 32'd3);
    chk("a_fx_cnt",  32'(fx_cnt), 32'd3);
    chk("a_rv_cnt",  32'(rv_cnt), 32'd1);
    chk("a_taken",   32'(taken_cnt), 32'd1);
    chk("a_branch",  32'(branch_cnt), 32'd1);

    // Fetch stalls 4 cycles; wrong-path PcSel/BrPC ignored
    clr_tally();
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1;
    BrPC = 32'h0000_0124; fetch_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b_hold_rv", {31'd0, redirect_valid}, 32'd1);
      chk("b_hold_pc", 32'(redirect_pc), 32'h124);
      PcSel = i[0];
      BrPC  = 32'h0000_00AA;
      tick();
    end
    chk("b_last_pc", 32'(redirect_pc), 32'h124);
    fetch_ready = 1'b1;
    drop_inputs();
    tick();
    drain("b_idle");
    chk("b_rv_cnt", 32'(rv_cnt), 32'd5);
    chk("b_fl_cnt", 32'(fl_cnt), 32'd7);
    chk("b_fx_cnt", 32'(fx_cnt), 32'd7);
    chk("b_taken",  32'(taken_cnt), 32'd2);
    chk("b_branch", 32'(branch_cnt), 32'd2);

    // JALR-style misaligned target
    clr_tally();
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1; BrPC = 32'h0000_0003;
    tick();
    chk("c_pc",  32'(redirect_pc), 32'h002);
    chk("c_mis", {31'd0, misalign_err}, 32'd1);
    drop_inputs();
    drain("c_idle");
    chk("c_mis_cnt", 32'(mis_cnt), 32'd1);

    // Upper target bits dropped, aligned target
    clr_tally();
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1; BrPC = 32'hFFFF_FE10;
    tick();
    chk("d_pc", 32'(redirect_pc), 32'h010);
    drop_inputs();
    drain("d_idle");
    chk("d_mis_cnt", 32'(mis_cnt), 32'd0);
    chk("d_taken",   32'(taken_cnt), 32'd4);

    // Not-taken branch counts branch only; PcSel without ex_branch counts taken only
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b0; BrPC = 32'h0000_0040;
    tick();
    chk("e_nt_busy",   {31'd0, busy}, 32'd0);
    chk("e_nt_branch", 32'(branch_cnt), 32'd5);
    chk("e_nt_taken",  32'(taken_cnt), 32'd4);
    ex_branch = 1'b0; PcSel = 1'b1;
    tick();
    chk("e_pc",     32'(redirect_pc), 32'h040);
    chk("e_branch", 32'(branch_cnt), 32'd5);
    chk("e_taken",  32'(taken_cnt), 32'd5);
    drop_inputs();
    drain("e_idle");

    // Reset during second REDIRECT wait cycle
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1;
    BrPC = 32'h0000_0124; fetch_ready = 1'b0;
    tick();
    tick();
    chk("f_pre_rv", {31'd0, redirect_valid}, 32'd1);
    reset = 1'b0;
    tick();
    chk("f_rv",    {31'd0, redirect_valid}, 32'd0);
    chk("f_pc",    32'(redirect_pc), 32'd0);
    chk("f_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    chk("f_busy",  {31'd0, busy}, 32'd0);
    chk("f_cnts",  {24'd0, branch_cnt, taken_cnt}, 32'd0);
    tick();
    chk("f_rst_prio_busy", {31'd0, busy}, 32'd0);
    drop_inputs();
    reset = 1'b1;
    tick();
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1; fetch_ready = 1'b1;
    tick();
    chk("f_recap_rv",    {31'd0, redirect_valid}, 32'd1);
    chk("f_recap_pc",    32'(redirect_pc), 32'h124);
    chk("f_recap_taken", 32'(taken_cnt), 32'd1);
    drop_inputs();
    drain("f_idle");

    // Saturation: 19 more taken branches on a 4-bit counter
    ex_valid = 1'b1; ex_branch = 1'b1; PcSel = 1'b1; fetch_ready = 1'b1;
    BrPC = 32'h0000_0100;
    for (int i = 0; i < 19 * 4; i++) tick();
    drop_inputs();
    drain("g_idle");
    chk("g_branch_sat", 32'(branch_cnt), 32'd15);
    chk("g_taken_sat",  32'(taken_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
